// File: rtl/ts4231_config_writer_if.sv
// Pad-side lines between the TS4231 config writer and the bidirectional
// pad manager: drive enables/values out, registered pad samples back.
interface ts4231_config_writer_if;
    logic d_oe;
    logic d_out;
    logic e_oe;
    logic e_out;
    logic d_in;
    logic e_in;

    modport master (
        output d_oe,
        output d_out,
        output e_oe,
        output e_out,
        input  d_in,
        input  e_in
    );

    modport slave (
        input  d_oe,
        input  d_out,
        input  e_oe,
        input  e_out,
        output d_in,
        output e_in
    );
endinterface

// File: rtl/ts4231_config_writer.sv
// Loads the TS4231 15-bit configuration word over the D/E lines, then
// releases both lines and checks that the sensor idles with them high.
module ts4231_config_writer #(
    parameter logic [14:0] CONFIG_WORD     = 15'h392B,
    parameter int          BIT_HALF_CYCLES = 96,
    parameter int          SETTLE_CYCLES   = 960
) (
    input  logic                          clk_96MHz,
    input  logic                          rst_n,
    input  logic                          start,
    ts4231_config_writer_if.master        pads,
    output logic                          busy,
    output logic                          done,
    output logic                          error
);

    typedef enum logic [1:0] {
        IDLE,
        SEQ,
        SETTLE,
        REPORT
    } state_t;

    localparam logic [9:0]  HALF_LAST   = 10'(BIT_HALF_CYCLES - 1);
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
    localparam logic [5:0]  LAST_STEP   = 6'd50;

    state_t      state;
    logic [5:0]  step;
    logic [9:0]  half_cnt;
    logic [15:0] settle_cnt;

    // Returns {E, D} for step k; bit steps are low/high/low on E
    // with D held, so D only moves while E is low.
    function automatic logic [1:0] pattern(input logic [5:0] k);
        logic [5:0] j;
        logic [5:0] q;
        logic [5:0] r;
        logic [3:0] i;
        j = k - 6'd3;
        q = j / 6'd3;
        r = j - q * 6'd3;
        i = 4'd14 - q[3:0];
        unique case (1'b1)
            k == 6'd0:               pattern = 2'b11;
            k == 6'd1:               pattern = 2'b10;
            k == 6'd2:               pattern = 2'b00;
            k >= 6'd3 && k <= 6'd47: pattern = {r == 6'd1, CONFIG_WORD[i]};
            k == 6'd48:              pattern = 2'b00;
            k == 6'd49:              pattern = 2'b10;
            default:                 pattern = 2'b11;
        endcase
    endfunction

    always_ff @(posedge clk_96MHz or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            step       <= '0;
            half_cnt   <= '0;
            settle_cnt <= '0;
            pads.d_oe  <= 1'b0;
            pads.d_out <= 1'b0;
            pads.e_oe  <= 1'b0;
            pads.e_out <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state    <= SEQ;
                        step     <= '0;
                        half_cnt <= '0;
                        error    <= 1'b0;
                        busy     <= 1'b1;
                        pads.d_oe <= 1'b1;
                        pads.e_oe <= 1'b1;
                        {pads.e_out, pads.d_out} <= pattern(6'd0);
                    end
                end
                SEQ: begin
                    if (half_cnt == HALF_LAST) begin
                        half_cnt <= '0;
                        if (step == LAST_STEP) begin
                            state      <= SETTLE;
                            settle_cnt <= '0;
                            pads.d_oe  <= 1'b0;
                            pads.d_out <= 1'b0;
                            pads.e_oe  <= 1'b0;
                            pads.e_out <= 1'b0;
                        end else begin
                            step <= step + 6'd1;
                            {pads.e_out, pads.d_out} <=
                                pattern(step + 6'd1);
                        end
                    end else begin
                        half_cnt <= half_cnt + 10'd1;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= REPORT;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        error <= !pads.e_in || !pads.d_in;
                    end else begin
                        settle_cnt <= settle_cnt + 16'd1;
                    end
                end
                REPORT: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
